short_stack_unit: RTL and testbench



---
 rtl/short_stack_unit.sv | 166 ++++++++++++++++
 tb/tb_short_stack_unit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/short_stack_unit.sv
// Per-ray short stack: takes push/pop/restnode-update requests from traversal and
// re-issues popped nodes (or the ray's restart node when empty) to the traversal arbiter.
module short_stack_unit #(
  parameter int          RAYID_W  = 4,
  parameter int          NODEID_W = 16,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] FAR_T    = 32'h7F80_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                raystart_valid,
  input  logic [RAYID_W-1:0]  raystart_rayID,
  input  logic                ss_valid,
  output logic                ss_stall,
  input  logic [RAYID_W-1:0]  ss_rayID,
  input  logic                ss_push_req,
  input  logic [NODEID_W-1:0] ss_push_node_ID,
  input  logic                ss_update_restnode_req,
  input  logic [NODEID_W-1:0] ss_rest_node_ID,
  input  logic                ss_pop_req,
  input  logic [31:0]         ss_t_max,
  output logic                ss_to_tarb_valid,
  input  logic                ss_to_tarb_stall,
  output logic [RAYID_W-1:0]  ss_to_tarb_rayID,
  output logic [NODEID_W-1:0] ss_to_tarb_nodeID,
  output logic                ss_to_tarb_restnode_search,
  output logic [31:0]         ss_to_tarb_t_max,
  output logic [31:0]         ss_to_tarb_t_min
);

  localparam int NRAYS = 1 << RAYID_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [NODEID_W-1:0] ent_node_q [NRAYS][DEPTH];
  logic [NODEID_W-1:0] ent_node_d [NRAYS][DEPTH];
  logic [31:0]         ent_t_q    [NRAYS][DEPTH];
  logic [31:0]         ent_t_d    [NRAYS][DEPTH];
  logic [PTR_W-1:0]    ptr_q      [NRAYS];
  logic [PTR_W-1:0]    ptr_d      [NRAYS];
  logic [CNT_W-1:0]    cnt_q      [NRAYS];
  logic [CNT_W-1:0]    cnt_d      [NRAYS];
  logic [NODEID_W-1:0] rest_q     [NRAYS];
  logic [NODEID_W-1:0] rest_d     [NRAYS];

  logic                out_vld_q, out_vld_d;
  logic [RAYID_W-1:0]  out_ray_q, out_ray_d;
  logic [NODEID_W-1:0] out_node_q, out_node_d;
  logic                out_rs_q, out_rs_d;
  logic [31:0]         out_tmax_q, out_tmax_d;
  logic [31:0]         out_tmin_q, out_tmin_d;

  logic                accept, do_push, do_pop, do_upd, keep;
  logic [PTR_W-1:0]    cur_ptr, top;
  logic [CNT_W-1:0]    cur_cnt;

  assign ss_stall = out_vld_q & ss_to_tarb_stall;

  always_comb begin
    accept  = ss_valid & ~ss_stall;
    do_push = accept & ss_push_req;
    do_pop  = accept & ss_pop_req & ~ss_push_req;
    do_upd  = accept & ss_update_restnode_req;
    // A raystart on the requesting ray discards the request's state update.
    keep    = ~(raystart_valid && (raystart_rayID == ss_rayID));
    cur_ptr = ptr_q[ss_rayID];
    cur_cnt = cnt_q[ss_rayID];
    top     = cur_ptr - PTR_W'(1);

    ent_node_d = ent_node_q;
    ent_t_d    = ent_t_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    rest_d     = rest_q;

    out_vld_d  = out_vld_q & ss_to_tarb_stall;
    out_ray_d  = out_ray_q;
    out_node_d = out_node_q;
    out_rs_d   = out_rs_q;
    out_tmax_d = out_tmax_q;
    out_tmin_d = out_tmin_q;

    if (do_pop) begin
      out_vld_d  = 1'b1;
      out_ray_d  = ss_rayID;
      out_tmin_d = ss_t_max;
      if (cur_cnt != '0) begin
        out_node_d = ent_node_q[ss_rayID][top];
        out_tmax_d = ent_t_q[ss_rayID][top];
        out_rs_d   = 1'b0;
      end else begin
        out_node_d = rest_q[ss_rayID];
        out_tmax_d = FAR_T;
        out_rs_d   = 1'b1;
      end
    end

    if (keep) begin
      if (do_push) begin
        ent_node_d[ss_rayID][cur_ptr] = ss_push_node_ID;
        ent_t_d[ss_rayID][cur_ptr]    = ss_t_max;
        ptr_d[ss_rayID]               = cur_ptr + PTR_W'(1);
        if (cur_cnt != CNT_W'(DEPTH))
          cnt_d[ss_rayID] = cur_cnt + CNT_W'(1);
      end
      if (do_upd)
        rest_d[ss_rayID] = ss_rest_node_ID;
      if (do_pop && (cur_cnt != '0)) begin
        ptr_d[ss_rayID] = top;
        cnt_d[ss_rayID] = cur_cnt - CNT_W'(1);
      end
    end

    if (raystart_valid) begin
      ptr_d[raystart_rayID]  = '0;
      cnt_d[raystart_rayID]  = '0;
      rest_d[raystart_rayID] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q      <= '{default: '0};
      cnt_q      <= '{default: '0};
      rest_q     <= '{default: '0};
      out_vld_q  <= 1'b0;
      out_ray_q  <= '0;
      out_node_q <= '0;
      out_rs_q   <= 1'b0;
      out_tmax_q <= '0;
      out_tmin_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      rest_q     <= rest_d;
      out_vld_q  <= out_vld_d;
      out_ray_q  <= out_ray_d;
      out_node_q <= out_node_d;
      out_rs_q   <= out_rs_d;
      out_tmax_q <= out_tmax_d;
      out_tmin_q <= out_tmin_d;
    end
  end

  // Entry payload is only read below a valid count, so it needs no reset.
  always_ff @(posedge clk) begin
    ent_node_q <= ent_node_d;
    ent_t_q    <= ent_t_d;
  end

  assign ss_to_tarb_valid           = out_vld_q;
  assign ss_to_tarb_rayID           = out_ray_q;
  assign ss_to_tarb_nodeID          = out_node_q;
  assign ss_to_tarb_restnode_search = out_rs_q;
  assign ss_to_tarb_t_max           = out_tmax_q;
  assign ss_to_tarb_t_min           = out_tmin_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst && ss_valid && !ss_stall)
      assert (!(ss_push_req && ss_pop_req))
        else $error("short_stack_unit: push and pop in one request");
  end
`endif

endmodule

// File: tb/tb_short_stack_unit.sv
// Bench for short_stack_unit: vector table of requests with expected re-issues,
// checked through a scoreboard queue, plus stall and mid-run reset sequences.
module tb_short_stack_unit;

  localparam logic [31:0] FAR = 32'h7F80_0000;

  logic        clk;
  logic        rst;
  logic        raystart_valid;
  logic [3:0]  raystart_rayID;
  logic        ss_valid;
  logic        ss_stall;
  logic [3:0]  ss_rayID;
  logic        ss_push_req;
  logic [15:0] ss_push_node_ID;
  logic        ss_update_restnode_req;
  logic [15:0] ss_rest_node_ID;
  logic        ss_pop_req;
  logic [31:0] ss_t_max;
  logic        ss_to_tarb_valid;
  logic        ss_to_tarb_stall;
  logic [3:0]  ss_to_tarb_rayID;
  logic [15:0] ss_to_tarb_nodeID;
  logic        ss_to_tarb_restnode_search;
  logic [31:0] ss_to_tarb_t_max;
  logic [31:0] ss_to_tarb_t_min;

  short_stack_unit dut (
    .clk                        (clk),
    .rst                        (rst),
    .raystart_valid             (raystart_valid),
    .raystart_rayID             (raystart_rayID),
    .ss_valid                   (ss_valid),
    .ss_stall                   (ss_stall),
    .ss_rayID                   (ss_rayID),
    .ss_push_req                (ss_push_req),
    .ss_push_node_ID            (ss_push_node_ID),
    .ss_update_restnode_req     (ss_update_restnode_req),
    .ss_rest_node_ID            (ss_rest_node_ID),
    .ss_pop_req                 (ss_pop_req),
    .ss_t_max                   (ss_t_max),
    .ss_to_tarb_valid           (ss_to_tarb_valid),
    .ss_to_tarb_stall           (ss_to_tarb_stall),
    .ss_to_tarb_rayID           (ss_to_tarb_rayID),
    .ss_to_tarb_nodeID          (ss_to_tarb_nodeID),
    .ss_to_tarb_restnode_search (ss_to_tarb_restnode_search),
    .ss_to_tarb_t_max           (ss_to_tarb_t_max),
    .ss_to_tarb_t_min           (ss_to_tarb_t_min)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          ray;
    bit          push;
    logic [15:0] pn;
    bit          upd;
    logic [15:0] rn;
    bit          pop;
    logic [31:0] t;
    bit          rs;
    int          rsray;
    logic [15:0] en;
    logic [31:0] etmax;
    bit          ers;
  } vec_t;

  typedef struct {
    logic [3:0]  ray;
    logic [15:0] node;
    logic [31:0] tmin;
    logic [31:0] tmax;
    logic        rsearch;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endfunction

  function automatic vec_t V(int ray, bit push, logic [15:0] pn, bit upd, logic [15:0] rn,
                             bit pop, logic [31:0] t, bit rs, int rsray,
                             logic [15:0] en, logic [31:0] etmax, bit ers);
    vec_t v;
    v.ray = ray; v.push = push; v.pn = pn; v.upd = upd; v.rn = rn; v.pop = pop;
    v.t = t; v.rs = rs; v.rsray = rsray; v.en = en; v.etmax = etmax; v.ers = ers;
    return v;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the request was accepted.
  task automatic req(input vec_t v);
    int   waits;
    exp_t e;
    waits = 0;
    ss_valid               = 1'b1;
    ss_rayID               = v.ray[3:0];
    ss_push_req            = v.push;
    ss_push_node_ID        = v.pn;
    ss_update_restnode_req = v.upd;
    ss_rest_node_ID        = v.rn;
    ss_pop_req             = v.pop;
    ss_t_max               = v.t;
    raystart_valid         = v.rs;
    raystart_rayID         = v.rsray[3:0];
    forever begin
      @(negedge clk);
      if (!ss_stall) break;
      waits++;
      if (waits > 50) break;
    end
    if (waits > 50) begin
      total++; bad++;
      $display("FAIL accept_timeout: ray %0d still stalled, want accepted", v.ray);
    end else if (v.pop && !v.push) begin
      e.ray = v.ray[3:0]; e.node = v.en; e.tmin = v.t; e.tmax = v.etmax; e.rsearch = v.ers;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    ss_valid = 1'b0; ss_push_req = 1'b0; ss_update_restnode_req = 1'b0;
    ss_pop_req = 1'b0; raystart_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst && ss_to_tarb_valid && !ss_to_tarb_stall) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_output: got node %h, want no output", ss_to_tarb_nodeID);
      end else begin
        e = sb.pop_front();
        chk("out_ray",   {28'd0, ss_to_tarb_rayID},  {28'd0, e.ray});
        chk("out_node",  {16'd0, ss_to_tarb_nodeID}, {16'd0, e.node});
        chk("out_tmin",  ss_to_tarb_t_min, e.tmin);
        chk("out_tmax",  ss_to_tarb_t_max, e.tmax);
        chk("out_rsrch", {31'd0, ss_to_tarb_restnode_search}, {31'd0, e.rsearch});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  vec_t vecs[$];

  initial begin
    rst = 1'b0; raystart_valid = 1'b0; raystart_rayID = '0; ss_valid = 1'b0;
    ss_rayID = '0; ss_push_req = 1'b0; ss_push_node_ID = '0; ss_update_restnode_req = 1'b0;
    ss_rest_node_ID = '0; ss_pop_req = 1'b0; ss_t_max = '0; ss_to_tarb_stall = 1'b1;

    // ray 3 restart from root
    vecs.push_back(V(3, 0, 0, 0, 0, 1, 32'h4000_0000, 0, 0, 16'd0, FAR, 1));
    // ray 1 two pushes, two pops, then empty
    vecs.push_back(V(1, 1, 5, 0, 0, 0, 32'h3F80_0000, 0, 0, 0, 0, 0));
    vecs.push_back(V(1, 1, 9, 0, 0, 0, 32'h4040_0000, 0, 0, 0, 0, 0));
    vecs.push_back(V(1, 0, 0, 0, 0, 1, 32'h3F00_0000, 0, 0, 16'd9, 32'h4040_0000, 0));
    vecs.push_back(V(1, 0, 0, 0, 0, 1, 32'h3FC0_0000, 0, 0, 16'd5, 32'h3F80_0000, 0));
    vecs.push_back(V(1, 0, 0, 0, 0, 1, 32'h0000_0001, 0, 0, 16'd0, FAR, 1));
    // ray 2 overflow: six pushes into four slots
    for (int n = 1; n <= 6; n++)
      vecs.push_back(V(2, 1, 16'(n), 0, 0, 0, 32'h100 + 32'(n), 0, 0, 0, 0, 0));
    for (int n = 6; n >= 3; n--)
      vecs.push_back(V(2, 0, 0, 0, 0, 1, 32'h200 + 32'(n), 0, 0, 16'(n), 32'h100 + 32'(n), 0));
    vecs.push_back(V(2, 0, 0, 0, 0, 1, 32'h0000_0002, 0, 0, 16'd0, FAR, 1));
    // ray 0 push with restnode update
    vecs.push_back(V(0, 1, 7, 1, 12, 0, 32'h11, 0, 0, 0, 0, 0));
    vecs.push_back(V(0, 0, 0, 0, 0, 1, 32'h20, 0, 0, 16'd7, 32'h11, 0));
    vecs.push_back(V(0, 0, 0, 0, 0, 1, 32'h21, 0, 0, 16'd12, FAR, 1));
    // ray 4 raystart wins over a same-cycle push
    vecs.push_back(V(4, 1, 3, 1, 20, 0, 32'h30, 0, 0, 0, 0, 0));
    vecs.push_back(V(4, 1, 8, 0, 0, 0, 32'h31, 1, 4, 0, 0, 0));
    vecs.push_back(V(4, 0, 0, 0, 0, 1, 32'h32, 0, 0, 16'd0, FAR, 1));
    // raystart on ray 6 while ray 7 pushes
    vecs.push_back(V(6, 0, 0, 1, 66, 0, 32'h0, 0, 0, 0, 0, 0));
    vecs.push_back(V(7, 1, 30, 0, 0, 0, 32'h70, 1, 6, 0, 0, 0));
    vecs.push_back(V(6, 0, 0, 0, 0, 1, 32'h1, 0, 0, 16'd0, FAR, 1));
    vecs.push_back(V(7, 0, 0, 0, 0, 1, 32'h2, 0, 0, 16'd30, 32'h70, 0));
    vecs.push_back(V(7, 0, 0, 0, 0, 1, 32'h3, 0, 0, 16'd0, FAR, 1));
    // pop with raystart on same ray: emits pre-clear top, then state cleared
    vecs.push_back(V(8, 1, 40, 0, 0, 0, 32'h80, 0, 0, 0, 0, 0));
    vecs.push_back(V(8, 1, 41, 0, 0, 0, 32'h81, 0, 0, 0, 0, 0));
    vecs.push_back(V(8, 0, 0, 0, 0, 1, 32'h4, 1, 8, 16'd41, 32'h81, 0));
    vecs.push_back(V(8, 0, 0, 0, 0, 1, 32'h5, 0, 0, 16'd0, FAR, 1));
    // no-flag request has no effect
    vecs.push_back(V(9, 1, 50, 0, 0, 0, 32'h90, 0, 0, 0, 0, 0));
    vecs.push_back(V(9, 0, 0, 0, 0, 0, 32'h91, 0, 0, 0, 0, 0));
    vecs.push_back(V(9, 0, 0, 0, 0, 1, 32'h6, 0, 0, 16'd50, 32'h90, 0));
    // restnode update alone
    vecs.push_back(V(10, 0, 0, 1, 77, 0, 32'h0, 0, 0, 0, 0, 0));
    vecs.push_back(V(10, 0, 0, 0, 0, 1, 32'h7, 0, 0, 16'd77, FAR, 1));
    // interleaved push/pop on ray 5
    vecs.push_back(V(5, 1, 1, 0, 0, 0, 32'h51, 0, 0, 0, 0, 0));
    vecs.push_back(V(5, 1, 2, 0, 0, 0, 32'h52, 0, 0, 0, 0, 0));
    vecs.push_back(V(5, 0, 0, 0, 0, 1, 32'h8, 0, 0, 16'd2, 32'h52, 0));
    vecs.push_back(V(5, 1, 3, 0, 0, 0, 32'h53, 0, 0, 0, 0, 0));
    vecs.push_back(V(5, 0, 0, 0, 0, 1, 32'h9, 0, 0, 16'd3, 32'h53, 0));
    vecs.push_back(V(5, 0, 0, 0, 0, 1, 32'hA, 0, 0, 16'd1, 32'h51, 0));

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'd0, ss_to_tarb_valid}, 32'd0);
    chk("rst_stall", {31'd0, ss_stall}, 32'd0);
    chk("rst_node",  {16'd0, ss_to_tarb_nodeID}, 32'd0);
    chk("rst_tmax",  ss_to_tarb_t_max, 32'd0);
    chk("rst_tmin",  ss_to_tarb_t_min, 32'd0);
    chk("rst_rsrch", {31'd0, ss_to_tarb_restnode_search}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1; ss_to_tarb_stall = 1'b0;

    foreach (vecs[i]) req(vecs[i]);
    repeat (2) begin @(posedge clk); #1; end
    chk("drain_table", sb.size(), 32'd0);

    // Stall: output held three cycles while a second request waits
    req(V(11, 1, 60, 0, 0, 0, 32'h60, 0, 0, 0, 0, 0));
    req(V(11, 0, 0, 0, 0, 1, 32'h61, 0, 0, 16'd60, 32'h60, 0));
    ss_to_tarb_stall = 1'b1;
    fork
      req(V(12, 0, 0, 0, 0, 1, 32'h62, 0, 0, 16'd0, FAR, 1));
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("stall_ss_stall", {31'd0, ss_stall}, 32'd1);
          chk("stall_valid", {31'd0, ss_to_tarb_valid}, 32'd1);
          chk("stall_node", {16'd0, ss_to_tarb_nodeID}, 32'd60);
          chk("stall_tmin", ss_to_tarb_t_min, 32'h61);
        end
        @(posedge clk); #1;
        ss_to_tarb_stall = 1'b0;
      end
    join
    @(negedge clk);
    chk("after_stall_node", {16'd0, ss_to_tarb_nodeID}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("valid_drop", {31'd0, ss_to_tarb_valid}, 32'd0);
    chk("drain_stall", sb.size(), 32'd0);
    @(posedge clk); #1;

    // Reset mid-operation drops the in-flight output and clears state
    req(V(13, 1, 70, 0, 0, 0, 32'h70, 0, 0, 0, 0, 0));
    req(V(13, 0, 0, 0, 0, 1, 32'hB, 0, 0, 16'd70, 32'h70, 0));
    ss_to_tarb_stall = 1'b1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; ss_to_tarb_stall = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("midrst_valid", {31'd0, ss_to_tarb_valid}, 32'd0);
    @(posedge clk); #1;
    req(V(13, 0, 0, 0, 0, 1, 32'hC, 0, 0, 16'd0, FAR, 1));
    req(V(10, 0, 0, 0, 0, 1, 32'hD, 0, 0, 16'd0, FAR, 1));
    repeat (3) begin @(posedge clk); #1; end
    chk("drain_final", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
